rc_filter_bank: RTL and testbench
=================================

# rc_filter_bank

Multi-channel, parametrised first-order RC low-pass model in signed fixed-point. It generalises the single RC filter to CHANNELS independent filters with a run-time time-constant, clear and enable controls, and per-channel settle detection. It sits between the stimulus/wrapper logic and the testbench or monitoring logic. One shared update datapath is time-multiplexed round-robin across the channels.

## Interface
- WIDTH, 16: sample/state width, signed two's complement.
- FRAC, 8: fractional bits. Informational for `TO_REAL scaling; the arithmetic does not depend on it.
- CHANNELS, 4: number of independent filters, 1..16.
- SETTLE_TOL, 16: settle threshold on |x - y|, in LSBs.
- SETTLE_COUNT, 8: consecutive in-tolerance updates required to assert settled.
- SHIFT_W, $clog2(WIDTH): width of the shift control.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  advance the sequencer and update one channel this cycle.
- clear  in  1  synchronous clear of all filter state. Takes precedence over en.
- shift  in  SHIFT_W  time-constant select: alpha = 2^-shift. Legal range 0..WIDTH-1.
- v_in  in  CHANNELS*WIDTH  packed inputs; channel c occupies bits [c*WIDTH +: WIDTH].
- v_out  out  CHANNELS*WIDTH  packed filter states, registered.
- out_valid  out  1  pulse: the channel in out_ch was updated on the previous edge.
- out_ch  out  $clog2(CHANNELS) (min 1)  index of the last updated channel.
- settled  out  CHANNELS  per-channel settle flag, registered.

## Operation
- Reset (rst = 0, asynchronous) sets the following to zero: all y[c], the pointer, out_valid, out_ch, settled and all settle counters.
- Sequencer: pointer p runs 0..CHANNELS-1 and wraps to 0. It advances only on an edge with en = 1 and clear = 0.
- Update for channel p on an en edge:
  - diff = x[p] - y[p], computed at WIDTH+1 bits.
  - step = diff >>> shift (arithmetic, floor).
  - y[p] <= y[p] + step, truncated to WIDTH.
- Range property: the new y always lies between the old y and x inclusive, so the result never overflows and needs no saturation.
- Steady-state error: y may stall up to 2^shift - 1 LSB below x for positive steps. For negative diff, floor guarantees motion of at least -1 LSB.
- shift = 0: y[p] = x[p] after a single update.
- shift ≥ WIDTH is illegal. The implementation clamps it to WIDTH-1.
- Settle counter (per channel, updated only when that channel updates):
  - If |diff| ≤ SETTLE_TOL, the counter increments, saturating at SETTLE_COUNT.
  - Otherwise the counter resets to 0.
  - settled[c] = (counter[c] == SETTLE_COUNT).
- clear = 1 on an edge: all y[c], all counters, settled and p go to 0, and out_valid goes to 0. This applies regardless of en.
- en = 0: all state holds and out_valid = 0.
- Channels not selected this cycle hold their state exactly.

## Timing
- v_in[p] and shift are sampled on the update edge. The new y[p] appears on v_out after that same edge (1-cycle latency).
- out_valid and out_ch are registered alongside y, so they are valid in the cycle following the update.
- With en held high, each channel updates exactly once every CHANNELS cycles, and out_ch cycles 0,1,…,CHANNELS-1,0.
- settled[c] changes only in the cycle after an update of channel c, after a clear, or on reset.
- Asynchronous reset assertion in mid-sequence takes effect immediately. After deassertion, the first en edge updates channel 0.

## Test plan
- Step response, CHANNELS=4, shift=1, x0 = 4096 (16.0), other channels 0, en high:
  - y0 reads 2048, 3072, 3584, 3840 on the four updates at cycles 1, 5, 9, 13.
  - v_out for channels 1..3 stays 0.
  - out_ch runs 0,1,2,3 repeating.
- shift=0, x2 = -300 → y2 = -300 after its first update. shift=4 with x = -1 and y = 0 → y = -1 after one update (floor behaviour).
- Settle: shift=4, x1 = 4096, SETTLE_TOL=16, SETTLE_COUNT=8:
  - y1 stalls at 4081 (error 15 LSB).
  - settled[1] rises after 8 consecutive updates with |diff| ≤ 16.
  - Changing x1 to 0 drops settled[1] one cycle after channel 1's next update.
- Gating: toggle en 1,0,0,1. Required response: p, y and out_ch hold across the low cycles, out_valid = 0 during them, and the sequence resumes at the next channel.
- clear asserted together with en while p = 2 and states are non-zero → next cycle all v_out = 0, settled = 0, out_valid = 0, p = 0.
- rst pulsed low asynchronously between edges mid-run → all outputs are 0 immediately. The first update after release is channel 0.

Source files
------------

// File: rtl/rc_filter_bank.sv
// Bank of CHANNELS first-order RC low-pass filters sharing one time-multiplexed
// update datapath; alpha = 2^-shift, with per-channel settle detection.
module rc_filter_bank #(
   parameter int WIDTH        = 16,
   parameter int FRAC         = 8,
   parameter int CHANNELS     = 4,
   parameter int SETTLE_TOL   = 16,
   parameter int SETTLE_COUNT = 8,
   parameter int SHIFT_W      = $clog2(WIDTH),
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        clear,
   input  logic [SHIFT_W-1:0]          shift,
   input  logic [CHANNELS*WIDTH-1:0]   v_in,
   output logic [CHANNELS*WIDTH-1:0]   v_out,
   output logic                        out_valid,
   output logic [CH_W-1:0]             out_ch,
   output logic [CHANNELS-1:0]         settled
);

   localparam int CNT_W = $clog2(SETTLE_COUNT + 1);
   localparam logic [CNT_W-1:0]   CNT_MAX   = CNT_W'(SETTLE_COUNT);
   localparam logic [WIDTH:0]     TOL       = (WIDTH + 1)'(SETTLE_TOL);
   localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(CHANNELS - 1);
   localparam logic [SHIFT_W-1:0] SHIFT_MAX = SHIFT_W'(WIDTH - 1);

   if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
      $error("rc_filter_bank: CHANNELS must be in 1..16");
   end
   if (FRAC < 0 || FRAC >= WIDTH) begin : g_bad_frac
      $error("rc_filter_bank: FRAC must be in 0..WIDTH-1");
   end
   if (SETTLE_COUNT < 1) begin : g_bad_count
      $error("rc_filter_bank: SETTLE_COUNT must be at least 1");
   end

   // Difference is formed one bit wider so x - y can never wrap.
   function automatic logic signed [WIDTH:0] rc_diff(input logic signed [WIDTH-1:0] x,
                                                     input logic signed [WIDTH-1:0] y);
      return $signed({x[WIDTH-1], x}) - $signed({y[WIDTH-1], y});
   endfunction

   // New state lies between y and x, so truncation back to WIDTH is exact.
   function automatic logic signed [WIDTH-1:0] rc_update(input logic signed [WIDTH-1:0] y,
                                                         input logic signed [WIDTH:0]   d,
                                                         input logic [SHIFT_W-1:0]      sh);
      return y + WIDTH'(d >>> sh);
   endfunction

   function automatic logic [WIDTH:0] abs_diff(input logic signed [WIDTH:0] d);
      return d[WIDTH] ? -d : d;
   endfunction

   function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
      return (s > SHIFT_MAX) ? SHIFT_MAX : s;
   endfunction

   logic [SHIFT_W-1:0]      shift_eff;

   // The clamp only exists when the shift port can encode values >= WIDTH.
   if ((2 ** SHIFT_W) > WIDTH) begin : g_clamp
      assign shift_eff = clamp_shift(shift);
   end else begin : g_no_clamp
      assign shift_eff = shift;
   end

   logic [CH_W-1:0]         p_q, p_d;
   logic signed [WIDTH-1:0] y_q [CHANNELS];
   logic signed [WIDTH-1:0] y_d [CHANNELS];
   logic [CNT_W-1:0]        cnt_q [CHANNELS];
   logic [CNT_W-1:0]        cnt_d [CHANNELS];
   logic [CHANNELS-1:0]     settled_q, settled_d;
   logic                    out_valid_q, out_valid_d;
   logic [CH_W-1:0]         out_ch_q, out_ch_d;
   logic signed [WIDTH-1:0] x_sel;
   logic signed [WIDTH:0]   diff;

   always_comb begin
      p_d         = p_q;
      y_d         = y_q;
      cnt_d       = cnt_q;
      settled_d   = settled_q;
      out_valid_d = 1'b0;
      out_ch_d    = out_ch_q;
      x_sel       = v_in[p_q*WIDTH +: WIDTH];
      diff        = rc_diff(x_sel, y_q[p_q]);
      if (clear) begin
         p_d       = '0;
         settled_d = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            y_d[c]   = '0;
            cnt_d[c] = '0;
         end
      end else if (en) begin
         y_d[p_q] = rc_update(y_q[p_q], diff, shift_eff);
         if (abs_diff(diff) <= TOL) begin
            cnt_d[p_q] = (cnt_q[p_q] == CNT_MAX) ? cnt_q[p_q] : cnt_q[p_q] + 1'b1;
         end else begin
            cnt_d[p_q] = '0;
         end
         settled_d[p_q] = (cnt_d[p_q] == CNT_MAX);
         out_valid_d    = 1'b1;
         out_ch_d       = p_q;
         p_d            = (p_q == CH_LAST) ? '0 : p_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_q         <= '0;
         settled_q   <= '0;
         out_valid_q <= 1'b0;
         out_ch_q    <= '0;
         for (int c = 0; c < CHANNELS; c++) begin
            y_q[c]   <= '0;
            cnt_q[c] <= '0;
         end
      end else begin
         p_q         <= p_d;
         y_q         <= y_d;
         cnt_q       <= cnt_d;
         settled_q   <= settled_d;
         out_valid_q <= out_valid_d;
         out_ch_q    <= out_ch_d;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_vout
      assign v_out[c*WIDTH +: WIDTH] = y_q[c];
   end

   assign out_valid = out_valid_q;
   assign out_ch    = out_ch_q;
   assign settled   = settled_q;

endmodule

// File: tb/tb_rc_filter_bank.sv
// Directed bench for rc_filter_bank: step response, shift corners, settle
// detection, enable gating, clear and asynchronous reset.
module tb_rc_filter_bank;

   localparam int W  = 16;
   localparam int CH = 4;
   localparam int SW = 4;

   logic              clk   = 1'b0;
   logic              rst   = 1'b1;
   logic              en    = 1'b0;
   logic              clear = 1'b0;
   logic [SW-1:0]     shift = '0;
   logic [CH*W-1:0]   v_in  = '0;
   logic [CH*W-1:0]   v_out;
   logic              out_valid;
   logic [1:0]        out_ch;
   logic [CH-1:0]     settled;

   int n_checks = 0;
   int n_errors = 0;

   rc_filter_bank #(
      .WIDTH(W), .FRAC(8), .CHANNELS(CH), .SETTLE_TOL(16), .SETTLE_COUNT(8), .SHIFT_W(SW)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .clear(clear), .shift(shift), .v_in(v_in),
      .v_out(v_out), .out_valid(out_valid), .out_ch(out_ch), .settled(settled)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [W-1:0] y_of(input int c);
      return v_out[c*W +: W];
   endfunction

   task automatic set_x(input int c, input logic signed [W-1:0] val);
      v_in[c*W +: W] = val;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int step_exp [4] = '{2048, 3072, 3584, 3840};

   initial begin
      // Asynchronous reset assertion before the first clock edge
      #2 rst = 1'b0;
      #1;
      chk("rst_vout", longint'(v_out), 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_ch", out_ch, 0);
      chk("rst_settled", settled, 0);
      tick();
      tick();
      chk("rst_hold_vout", longint'(v_out), 0);

      // Step response on channel 0, shift = 1
      rst   = 1'b1;
      en    = 1'b1;
      shift = 4'd1;
      set_x(0, 16'sd4096);
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < CH; c++) begin
            tick();
            chk($sformatf("step_valid_%0d_%0d", k, c), out_valid, 1);
            chk($sformatf("step_ch_%0d_%0d", k, c), out_ch, c);
            if (c == 0) chk($sformatf("step_y0_%0d", k), y_of(0), step_exp[k]);
         end
      end
      for (int c = 1; c < CH; c++) chk($sformatf("step_idle_y%0d", c), y_of(c), 0);

      // shift = 0 reaches the input in one update
      shift = 4'd0;
      set_x(2, -16'sd300);
      tick();
      tick();
      tick();
      chk("sh0_y2", y_of(2), -300);
      chk("sh0_y0", y_of(0), 4096);
      tick();

      // Floor behaviour: x = -1, y = 0, shift = 4 moves by -1
      shift = 4'd4;
      set_x(3, -16'sd1);
      repeat (4) tick();
      chk("floor_y3", y_of(3), -1);
      chk("floor_y2_hold", y_of(2), -300);

      // Enable gating 1,0,0,1
      tick();
      chk("gate_ch0", out_ch, 0);
      chk("gate_valid0", out_valid, 1);
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk($sformatf("gate_low_valid_%0d", i), out_valid, 0);
         chk($sformatf("gate_low_ch_%0d", i), out_ch, 0);
         chk($sformatf("gate_low_y0_%0d", i), y_of(0), 4096);
         chk($sformatf("gate_low_y2_%0d", i), y_of(2), -300);
         chk($sformatf("gate_low_y3_%0d", i), y_of(3), -1);
      end
      en = 1'b1;
      tick();
      chk("gate_resume_ch", out_ch, 1);
      chk("gate_resume_valid", out_valid, 1);

      // Clear together with en while the pointer sits at channel 2
      clear = 1'b1;
      tick();
      chk("clr_vout", longint'(v_out), 0);
      chk("clr_settled", settled, 0);
      chk("clr_valid", out_valid, 0);
      clear = 1'b0;
      tick();
      chk("clr_next_ch", out_ch, 0);
      chk("clr_next_y0", y_of(0), 256);

      // Settle: shift = 0, channel 1 jumps then sees diff 0 on every later update
      shift = 4'd0;
      set_x(1, 16'sd4096);
      for (int n = 1; n <= 9; n++) begin
         tick();
         chk($sformatf("settle_ch_%0d", n), out_ch, 1);
         if (n == 8) chk("settle_before", settled[1], 0);
         if (n == 9) chk("settle_rise", settled[1], 1);
         repeat (3) tick();
      end
      chk("settle_y1", y_of(1), 4096);

      // Moving the target drops settled right after channel 1's next update
      set_x(1, 16'sd0);
      tick();
      chk("drop_settled", settled[1], 0);
      chk("drop_y1", y_of(1), 0);
      repeat (3) tick();

      // shift = 4 toward 4096 stalls 15 LSB short and settles there
      shift = 4'd4;
      set_x(1, 16'sd4096);
      repeat (150) begin
         tick();
         repeat (3) tick();
      end
      chk("stall_y1", y_of(1), 4081);
      chk("stall_settled", settled[1], 1);
      tick();
      chk("stall_ch", out_ch, 1);

      // Asynchronous reset between clock edges
      #2 rst = 1'b0;
      #1;
      chk("arst_vout", longint'(v_out), 0);
      chk("arst_valid", out_valid, 0);
      chk("arst_ch", out_ch, 0);
      chk("arst_settled", settled, 0);
      #1 rst = 1'b1;
      shift = 4'd1;
      set_x(0, 16'sd4096);
      tick();
      chk("arst_first_ch", out_ch, 0);
      chk("arst_first_valid", out_valid, 1);
      chk("arst_first_y0", y_of(0), 2048);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
